reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Reset sequencer for the FPGA top level. Holds a set of downstream reset domains in reset until the clock source is locked and all requests are clear. Releases the domains one at a time in ascending index order, and on a reset request re-asserts them in descending order. Sits between the board reset and PLL lock inputs and the per-domain reset synchronizers of each IP block.

## Interface
- N_DOMAINS, 4: number of sequenced reset domains, legal range 1..16.
- HOLD_CYCLES, 16: qualified cycles in HOLD before release starts, ≥1.
- STAGE_DELAY, 8: cycles between successive domain release/assert steps, ≥1.
- SYNC_STAGES, 2: flops in each input synchronizer, ≥2.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset (the only reset).
- pll_locked  in  1  asynchronous; clock source lock status.
- ext_rst_req  in  1  asynchronous, active-high, level; board button or debug reset.
- sw_rst_req  in  1  synchronous to clk, single-cycle pulse from a control register.
- domain_rst  out  N_DOMAINS  active-high reset per domain; bit 0 is released first.
- seq_done  out  1  high only in RUN.
- busy  out  1  high in HOLD, RELEASE and DRAIN.
- state  out  2  current FSM state encoding.

## Operation
- pll_locked and ext_rst_req each pass through a SYNC_STAGES flop synchronizer; the FSM sees only the synchronized values (lock_s, ext_s).
- qualified = lock_s & !ext_s & !sw_rst_req.
- States and codes: HOLD=0, RELEASE=1, RUN=2, DRAIN=3.
- HOLD:
  - All domain_rst bits are 1.
  - The counter increments on qualified cycles and clears on any unqualified cycle.
  - When counter = HOLD_CYCLES-1 and the cycle is qualified: go to RELEASE, idx=0.
- RELEASE:
  - domain_rst[idx] clears at each step, then idx increments and the counter reloads.
  - Steps are STAGE_DELAY cycles apart.
  - After bit N_DOMAINS-1 clears: go to RUN.
  - Any request (ext_s or sw_rst_req) aborts: all bits set to 1 on the next edge, go to HOLD.
- RUN:
  - domain_rst all 0, seq_done=1.
  - A request moves to DRAIN, idx=N_DOMAINS-1.
- DRAIN:
  - domain_rst[idx] sets to 1 at each step, STAGE_DELAY cycles apart, descending order.
  - After bit 0 is set: go to HOLD.
  - Requests arriving during DRAIN are absorbed and do not restart the drain.
- Counter width: $clog2(max(HOLD_CYCLES,STAGE_DELAY)+1). idx width: $clog2(N_DOMAINS), minimum 1.
- N_DOMAINS=1: RELEASE and DRAIN each take a single step.

## Timing
- Reset values: domain_rst all ones, seq_done=0, busy=1, state=HOLD, counter=0, idx=0, synchronizer flops=0.
- rst_n assertion mid-sequence, in any state, forces the reset values asynchronously.
- Input latency: SYNC_STAGES edges from an async input change to its FSM effect. sw_rst_req acts on the next edge.
- Let t0 be the edge that enters RELEASE:
  - domain_rst[0] is 0 after t0.
  - domain_rst[k] is 0 after t0 + k·STAGE_DELAY.
  - RUN and seq_done=1 after t0 + (N_DOMAINS-1)·STAGE_DELAY.
- Drain mirrors this: bit N_DOMAINS-1 sets on the edge that enters DRAIN, and bit k sets (N_DOMAINS-1-k)·STAGE_DELAY edges later.
- HOLD is entered on the same edge that sets bit 0.
- All outputs are registered; no combinational path from any input to any output.
- Loss of lock outside HOLD: see Configuration.

## Configuration
- RESET_SEQ_LOCK_MONITOR_EN defined:
  - lock_s=0 in RELEASE or RUN counts as a request: RELEASE aborts to HOLD, RUN enters DRAIN.
  - A sticky lock_lost output bit is added; it is cleared only by rst_n.
- Not defined: pll_locked only gates HOLD exit, and no lock_lost port exists.

## Structure
- Shared package reset_seq_pkg:
  - state encoding constants HOLD/RELEASE/RUN/DRAIN, 2-bit state type;
  - counter width helper function.
- Sub-module reset_req_sync: generic SYNC_STAGES flop bit synchronizer with ASYNC_REG attribute on its flops and async active-low clear. Instantiated twice, once for pll_locked and once for ext_rst_req.

## Test plan
- Power-up, defaults, pll_locked=1 throughout:
  - domain_rst=4'hF, then bits clear at cycles t0, t0+8, t0+16, t0+24;
  - seq_done=1 at t0+24;
  - t0 = 2 sync cycles + 16 hold cycles after rst_n release.
- pll_locked drops for 3 cycles during HOLD count → counter restarts; release starts 16 qualified cycles after lock returns.
- sw_rst_req pulse in RUN:
  - state=DRAIN next cycle;
  - bits set in order 3, 2, 1, 0 at 8-cycle spacing;
  - HOLD, then a full re-release.
- ext_rst_req asserted after domain 1 released → after sync latency all bits = 1 in one edge, state=HOLD; nothing releases while ext_rst_req is held.
- rst_n pulsed low mid-RELEASE → domain_rst=all ones immediately, without waiting for a clock edge; state=HOLD; seq_done=0.
- With RESET_SEQ_LOCK_MONITOR_EN: pll_locked dropped in RUN → DRAIN entered, lock_lost=1 and stays 1 after the resequence.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and counter sizing.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      DRAIN   = 2'd3
   } seq_state_e;

   // One counter serves both the HOLD qualification count and the inter-step delay.
   function automatic int cnt_width(input int hold_cycles, input int stage_delay);
      int m;
      m = (hold_cycles > stage_delay) ? hold_cycles : stage_delay;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_req_sync.sv
// Multi-flop bit synchronizer for asynchronous reset-related inputs; clears to 0 on rst_n.
module reset_req_sync
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequences downstream reset domains: ascending release once locked and quiet, descending drain on request.
// Optional loss-of-lock monitoring and sticky lock_lost output: define RESET_SEQ_LOCK_MONITOR_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int N_DOMAINS   = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_DELAY = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pll_locked,
   input  logic                 ext_rst_req,
   input  logic                 sw_rst_req,
   output logic [N_DOMAINS-1:0] domain_rst,
   output logic                 seq_done,
   output logic                 busy,
   output logic [1:0]           state
`ifdef RESET_SEQ_LOCK_MONITOR_EN
   ,
   output logic                 lock_lost
`endif
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_DELAY);
   localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGE_RLD = CNT_W'(STAGE_DELAY - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

   logic lock_s;
   logic ext_s;
   logic qualified;
   logic req;

   seq_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [N_DOMAINS-1:0]   domain_rst_q, domain_rst_d;
   logic                   seq_done_q, seq_done_d;
   logic                   busy_q, busy_d;
   logic [N_DOMAINS-1:0]   step_mask;

   reset_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lock_s)
   );

   reset_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ext_rst_req),
      .q     (ext_s)
   );

   assign qualified = lock_s & ~ext_s & ~sw_rst_req;

`ifdef RESET_SEQ_LOCK_MONITOR_EN
   assign req = ext_s | sw_rst_req | ~lock_s;
`else
   assign req = ext_s | sw_rst_req;
`endif

   // One-hot of the domain addressed by the next release/drain step.
   genvar gi;
   for (gi = 0; gi < N_DOMAINS; gi++) begin : g_step_mask
      assign step_mask[gi] = (idx_q == IDX_W'(gi));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HOLD;
         cnt_q        <= '0;
         idx_q        <= '0;
         domain_rst_q <= '1;
         seq_done_q   <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         domain_rst_q <= domain_rst_d;
         seq_done_q   <= seq_done_d;
         busy_q       <= busy_d;
      end
   end

   // The first release step and the first drain step happen on the edge that
   // enters RELEASE/DRAIN; idx then points at the next domain to touch. With a
   // single domain that one step is the whole sequence, so the FSM moves
   // straight to RUN/HOLD on that edge.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      domain_rst_d = domain_rst_q;
      case (state_q)
         HOLD: begin
            domain_rst_d = '1;
            if (!qualified) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               domain_rst_d[0] = 1'b0;
               cnt_d           = STAGE_RLD;
               idx_d           = (N_DOMAINS == 1) ? '0 : IDX_W'(1);
               state_d         = (N_DOMAINS == 1) ? RUN : RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (req) begin
               domain_rst_d = '1;
               cnt_d        = '0;
               idx_d        = '0;
               state_d      = HOLD;
            end else if (cnt_q == '0) begin
               domain_rst_d = domain_rst_q & ~step_mask;
               cnt_d        = STAGE_RLD;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = RUN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RUN: begin
            domain_rst_d = '0;
            if (req) begin
               domain_rst_d[N_DOMAINS-1] = 1'b1;
               if (N_DOMAINS == 1) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = HOLD;
               end else begin
                  cnt_d   = STAGE_RLD;
                  idx_d   = IDX_W'(N_DOMAINS - 2);
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Requests are deliberately ignored here: the drain always completes.
            if (cnt_q == '0) begin
               domain_rst_d = domain_rst_q | step_mask;
               if (idx_q == '0) begin
                  cnt_d   = '0;
                  state_d = HOLD;
               end else begin
                  cnt_d = STAGE_RLD;
                  idx_d = idx_q - 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            domain_rst_d = '1;
            cnt_d        = '0;
            idx_d        = '0;
            state_d      = HOLD;
         end
      endcase
   end

   always_comb begin
      seq_done_d = (state_d == RUN);
      busy_d     = (state_d != RUN);
   end

`ifdef RESET_SEQ_LOCK_MONITOR_EN
   logic lock_lost_q, lock_lost_d;

   always_comb begin
      lock_lost_d = lock_lost_q | (~lock_s & ((state_q == RELEASE) | (state_q == RUN)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_lost_q <= 1'b0;
      end else begin
         lock_lost_q <= lock_lost_d;
      end
   end

   assign lock_lost = lock_lost_q;
`endif

   assign domain_rst = domain_rst_q;
   assign seq_done   = seq_done_q;
   assign busy       = busy_q;
   assign state      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes, a monitor checks each change.
module tb_reset_sequencer;

   localparam logic [1:0] S_HOLD  = 2'd0;
   localparam logic [1:0] S_REL   = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       ext_rst_req;
   logic       sw_rst_req;
   logic [3:0] domain_rst;
   logic       seq_done;
   logic       busy;
   logic [1:0] state;
`ifdef RESET_SEQ_LOCK_MONITOR_EN
   logic       lock_lost;
`endif

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int txn = 0;

   typedef struct {
      int         cyc;
      logic [3:0] dom;
      logic [1:0] st;
      int         tag;
   } exp_t;

   exp_t exp_q[$];

   reset_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .ext_rst_req (ext_rst_req),
      .sw_rst_req  (sw_rst_req),
      .domain_rst  (domain_rst),
      .seq_done    (seq_done),
      .busy        (busy),
      .state       (state)
`ifdef RESET_SEQ_LOCK_MONITOR_EN
      ,
      .lock_lost   (lock_lost)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // Monitor: every change of the visible outputs is one transaction.
   logic [7:0] prev_obs = {4'hF, 2'd0, 1'b0, 1'b1};

   always @(negedge clk) begin : monitor
      logic [7:0] obs;
      logic [7:0] exp_obs;
      exp_t       e;
      obs = {domain_rst, state, seq_done, busy};
      if (obs != prev_obs) begin
         vectors++;
         txn++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_change cyc=%0d got dom=%h state=%0d done=%0d busy=%0d required no change",
                     cyc, domain_rst, state, seq_done, busy);
         end else begin
            e = exp_q.pop_front();
            exp_obs = {e.dom, e.st, (e.st == S_RUN), (e.st != S_RUN)};
            if (obs !== exp_obs || cyc != e.cyc) begin
               miscompares++;
               $display("FAIL step_%0d got cyc=%0d obs=%h required cyc=%0d obs=%h",
                        e.tag, cyc, obs, e.cyc, exp_obs);
            end else begin
               $display("txn %0d step_%0d cyc=%0d dom=%h state=%0d ok", txn, e.tag, cyc, domain_rst, state);
            end
         end
         prev_obs = obs;
      end
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end else begin
         $display("txn direct %s cyc=%0d value=%h ok", name, cyc, got);
      end
   endtask

   task automatic goto(input int n);
      while (cyc != n) @(negedge clk);
   endtask

   task automatic push(input int c, input logic [3:0] d, input logic [1:0] s, input int tag);
      exp_t e;
      e.cyc = c;
      e.dom = d;
      e.st  = s;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Release of 4 domains, 8 cycles apart, starting at edge t0.
   task automatic push_rel(input int t0, input int steps, input int tag);
      if (steps > 0) push(t0,      4'hE, S_REL, tag);
      if (steps > 1) push(t0 + 8,  4'hC, S_REL, tag + 1);
      if (steps > 2) push(t0 + 16, 4'h8, S_REL, tag + 2);
      if (steps > 3) push(t0 + 24, 4'h0, S_RUN, tag + 3);
   endtask

   task automatic push_drain(input int c0, input int tag);
      push(c0,      4'h8, S_DRAIN, tag);
      push(c0 + 8,  4'hC, S_DRAIN, tag + 1);
      push(c0 + 16, 4'hE, S_DRAIN, tag + 2);
      push(c0 + 24, 4'hF, S_HOLD,  tag + 3);
   endtask

   initial begin : stimulus
      int   t;
      int   g;
      int   c;
      int   d;
      int   e;
      int   f;
      int   h;
      int   last;
      exp_t x;

      rst_n       = 1'b1;
      pll_locked  = 1'b1;
      ext_rst_req = 1'b0;
      sw_rst_req  = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("reset_state", {domain_rst, state, seq_done, busy}, {4'hF, S_HOLD, 1'b0, 1'b1});
`ifdef RESET_SEQ_LOCK_MONITOR_EN
      check("lock_lost_reset", {7'd0, lock_lost}, 8'd0);
`endif

      // Power-up: 2 sync edges + 16 hold edges, then async reset mid-RELEASE.
      goto(3);
      rst_n = 1'b1;
      t = 3 + 18;
      push_rel(t, 2, 60);
      push(t + 13, 4'hF, S_HOLD, 62);
      goto(t + 12);
      #2 rst_n = 1'b0;
      #1 check("async_reset", {domain_rst, state, seq_done, busy}, {4'hF, S_HOLD, 1'b0, 1'b1});
      goto(t + 15);
      rst_n = 1'b1;
      g = t + 15;

      // Clean power-up release to RUN.
      t = g + 18;
      push_rel(t, 4, 10);

      // Software reset pulse in RUN: drain 3,2,1,0.
      c = t + 26;
      goto(c);
      check("seq_done_run", {7'd0, seq_done}, 8'd1);
      sw_rst_req = 1'b1;
      push_drain(c + 1, 20);
      goto(c + 1);
      sw_rst_req = 1'b0;

      // Lock drops 3 cycles during HOLD count: counter restarts.
      d = c + 30;
      goto(d);
      pll_locked = 1'b0;
      goto(d + 3);
      pll_locked = 1'b1;
      t = d + 21;
      push_rel(t, 2, 30);

      // External request after domain 1 released: abort to HOLD after sync latency.
      e = t + 10;
      goto(e);
      ext_rst_req = 1'b1;
      push(e + 3, 4'hF, S_HOLD, 40);
      f = e + 43;
      goto(f - 1);
      check("ext_held_hold", {domain_rst, state}, {4'hF, S_HOLD});
      goto(f);
      ext_rst_req = 1'b0;
      t = f + 18;
      push_rel(t, 4, 50);
      h = t + 28;
      last = h;

`ifdef RESET_SEQ_LOCK_MONITOR_EN
      goto(h);
      check("lock_lost_before", {7'd0, lock_lost}, 8'd0);
      pll_locked = 1'b0;
      push_drain(h + 3, 70);
      goto(h + 4);
      check("lock_lost_set", {7'd0, lock_lost}, 8'd1);
      goto(h + 30);
      pll_locked = 1'b1;
      t = h + 48;
      push_rel(t, 4, 75);
      goto(t + 30);
      check("lock_lost_sticky", {7'd0, lock_lost}, 8'd1);
      last = t + 30;
`endif

      goto(last + 20);
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL step_%0d got no change required change at cyc=%0d dom=%h state=%0d",
                  x.tag, x.cyc, x.dom, x.st);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
